ap_tag_resolver: RTL

- Multiple-response resolver downstream of the CAM cell array; consumes the per-row match vector tag_row produced after a compare pass.
- On start, snapshots the vector and reports any_match and match_count.
- Then issues matched row addresses lowest-index-first over a valid/ready handshake.
- The controller feeds each address back as addr_input_Row / addr_output_Row for per-row write or readout.

---
 rtl/ap_tag_resolver.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ap_tag_resolver.sv
// ap_tag_resolver: resolves the multiple matches of one CAM compare pass.
// On start it captures the per-row match vector, reports any_match and
// match_count, then hands out the matched row addresses lowest index first
// over a valid/ready handshake. The resolve ends with a one-cycle done pulse,
// which also covers the empty and aborted cases.
//
// Ports:
//   clk, rstIn          clock, asynchronous active-high reset
//   tag_row             per-row match flags (bit i = row i matched)
//   start               capture tag_row and begin a resolve (IDLE only)
//   abort               end an in-progress resolve early
//   out_ready           consumer accepts out_addr
//   busy                any state other than IDLE
//   any_match           OR of the captured vector
//   match_count         popcount of the captured vector
//   out_valid           out_addr is valid
//   out_addr            lowest remaining matched row
//   out_last            out_addr is the final remaining match
//   served_count        addresses transferred since the last start
//   done                one-cycle end-of-resolve pulse
//   aborted             the last resolve ended by abort
module ap_tag_resolver #(
    parameter int unsigned DATA_DEPTH     = 16,
    parameter int unsigned ADDR_WIDTH_CAM = 8
) (
    input  logic                      clk,
    input  logic                      rstIn,
    input  logic [DATA_DEPTH-1:0]     tag_row,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      any_match,
    output logic [ADDR_WIDTH_CAM-1:0] match_count,
    output logic                      out_valid,
    output logic [ADDR_WIDTH_CAM-1:0] out_addr,
    output logic                      out_last,
    output logic [ADDR_WIDTH_CAM-1:0] served_count,
    output logic                      done,
    output logic                      aborted
);

    localparam int unsigned DW = DATA_DEPTH;
    localparam int unsigned AW = ADDR_WIDTH_CAM;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        FINISH  = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [DW-1:0]   snap, snap_d;
    logic            any_match_d;
    logic [AW-1:0]   match_count_d;
    logic [AW-1:0]   served_count_d;
    logic            aborted_d;
    logic            xfer;

    // Number of set bits, zero-extended to the address width.
    function automatic logic [AW-1:0] popcount(input logic [DW-1:0] v);
        logic [AW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(DW); i++) begin
            cnt = cnt + AW'(v[i]);
        end
        return cnt;
    endfunction

    // Index of the lowest set bit; scanning downwards lets row 0 win.
    function automatic logic [AW-1:0] lowest_set(input logic [DW-1:0] v);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = int'(DW) - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = AW'(i);
            end
        end
        return idx;
    endfunction

    // Exactly one bit set: non-zero and clearing the lowest bit leaves zero.
    function automatic logic is_single(input logic [DW-1:0] v);
        return (v != '0) && ((v & (v - DW'(1))) == '0);
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and next-value logic for the snapshot and status registers.
    always_comb begin
        state_d        = state;
        snap_d         = snap;
        any_match_d    = any_match;
        match_count_d  = match_count;
        served_count_d = served_count;
        aborted_d      = aborted;
        xfer           = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    snap_d         = tag_row;
                    any_match_d    = |tag_row;
                    match_count_d  = popcount(tag_row);
                    served_count_d = '0;
                    aborted_d      = 1'b0;
                    state_d        = (tag_row != '0) ? RESOLVE : FINISH;
                end
            end
            RESOLVE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = FINISH;
                end else if (out_ready) begin
                    xfer = 1'b1;
                    // Clearing the lowest set bit retires the presented address.
                    snap_d         = snap & (snap - DW'(1));
                    served_count_d = served_count + AW'(1);
                    if (is_single(snap)) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and output registers; handshake outputs are decoded from the
    // next snapshot so the address is ready in the same cycle as out_valid.
    always_ff @(posedge clk or posedge rstIn) begin
        if (rstIn) begin
            snap         <= '0;
            any_match    <= 1'b0;
            match_count  <= '0;
            served_count <= '0;
            aborted      <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            out_addr     <= '0;
            out_last     <= 1'b0;
        end else begin
            snap         <= snap_d;
            any_match    <= any_match_d;
            match_count  <= match_count_d;
            served_count <= served_count_d;
            aborted      <= aborted_d;
            done         <= (state_d == FINISH);
            busy         <= (state_d != IDLE);
            out_valid    <= (state_d == RESOLVE);
            out_addr     <= (state_d == RESOLVE) ? lowest_set(snap_d) : '0;
            out_last     <= (state_d == RESOLVE) && is_single(snap_d);
        end
    end

    // Transfer strobe is only used to structure the next-state logic.
    logic unused_xfer;
    assign unused_xfer = xfer;

endmodule
